uart_frame_buffer: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its byte stream: data byte, active-low write strobe and down-counting write address (112 down to 1 per frame).
- Assembles each 112-byte frame into one of two internal banks (ping-pong).
- On frame completion, swaps banks and presents the finished frame on a registered random-access read port to the pulse-pattern generator.
- The receiver's UART clock is derived from the same system clock, so all inputs are sampled in the clk domain without CDC logic.

---
 rtl/uart_frame_buffer_if.sv | 41 ++++
 rtl/uart_frame_buffer.sv | 162 ++++++++++++++++
 tb/tb_uart_frame_buffer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_buffer_if.sv
// Bundle between the UART receiver byte stream, the ping-pong frame buffer
// and the pulse-pattern generator's random-access read port.
interface uart_frame_buffer_if #(
  parameter int AW = 7
);
  logic [7:0]    rx_data;
  logic          rx_wr_n;
  logic [7:0]    rx_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ready;
  logic          frame_valid;
  logic [7:0]    frame_cnt;
  logic          frame_err;

  // Receiver and pattern-generator side.
  modport master (
    output rx_data,
    output rx_wr_n,
    output rx_addr,
    output rd_addr,
    input  rd_data,
    input  frame_ready,
    input  frame_valid,
    input  frame_cnt,
    input  frame_err
  );

  // Frame buffer side.
  modport slave (
    input  rx_data,
    input  rx_wr_n,
    input  rx_addr,
    input  rd_addr,
    output rd_data,
    output frame_ready,
    output frame_valid,
    output frame_cnt,
    output frame_err
  );
endinterface

// File: rtl/uart_frame_buffer.sv
// Ping-pong frame assembler: collects FRAME_LEN bytes from the UART receiver
// into the write bank, then swaps so the finished frame is readable.
module uart_frame_buffer #(
  parameter int FRAME_LEN = 112,
  parameter int AW        = 7
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam logic [7:0]    LEN_B    = 8'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic [AW:0]   LEN_RD   = (AW + 1)'(FRAME_LEN);
  localparam int            DEPTH    = 2 ** (AW + 1);

  // Memory is addressed {bank, idx}; the read bank is always ~wbank.
  logic [7:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic          wbank_q, wbank_d;
  logic          wr_n_q, wr_n_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    rd_data_q;

  logic          byte_ev;
  logic          addr_ok;
  logic [AW-1:0] ev_idx;
  logic          we;
  logic [AW-1:0] w_idx;

  // Receiver counts addresses down, so the first byte of a frame is idx 0.
  assign ev_idx  = AW'(LEN_B - bus.rx_addr);
  assign addr_ok = (bus.rx_addr != 8'd0) && (bus.rx_addr <= LEN_B);

  // The strobe history is frozen during SWAP, so no edge is consumed there.
  assign byte_ev = (state_q != SWAP) && wr_n_q && !bus.rx_wr_n;

  // NOTE: every signal written below gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    wbank_d = wbank_q;
    err_d   = err_q;
    ready_d = 1'b0;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    w_idx   = ev_idx;
    wr_n_d  = (state_q == SWAP) ? wr_n_q : bus.rx_wr_n;

    unique case (state_q)
      IDLE: begin
        if (byte_ev) begin
          if (addr_ok && (ev_idx == '0)) begin
            we      = 1'b1;
            fill_d  = AW'(1);
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      FILL: begin
        if (byte_ev) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else if (ev_idx == fill_q) begin
            we     = 1'b1;
            fill_d = fill_q + 1'b1;
            if (ev_idx == LAST_IDX) begin
              state_d = SWAP;
            end
          end else if (ev_idx == '0) begin
            // A new frame start mid-frame: restart assembly from this byte.
            we     = 1'b1;
            fill_d = AW'(1);
            err_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            fill_d  = '0;
            state_d = IDLE;
          end
        end
      end

      SWAP: begin
        wbank_d = ~wbank_q;
        ready_d = 1'b1;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        fill_d  = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      wbank_q <= 1'b0;
      wr_n_q  <= 1'b1;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wbank_q <= wbank_d;
      wr_n_q  <= wr_n_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the frame memory has no reset so it maps onto block RAM; frame_valid
  // tells the consumer when its contents are meaningful.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[{wbank_q, w_idx}] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 8'd0;
    end else if ({1'b0, bus.rd_addr} < LEN_RD) begin
      rd_data_q <= mem[{~wbank_q, bus.rd_addr}];
    end else begin
      rd_data_q <= 8'd0;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_ready = ready_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Self-checking bench for uart_frame_buffer: table vectors, hand-written
// corner sequences and a randomized byte stream against a frame-level model.
module tb_uart_frame_buffer;
  localparam int FRAME_LEN = 112;
  localparam int AW        = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_buffer_if #(.AW(AW)) bus ();

  uart_frame_buffer #(.FRAME_LEN(FRAME_LEN), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ready_seen  = 0;

  always @(negedge clk) if (bus.frame_ready === 1'b1) ready_seen++;

  // Frame-level reference model: a committed frame, a partial frame and the
  // count of contiguous bytes collected so far (0 means waiting for a start).
  logic [7:0] m_part  [FRAME_LEN];
  logic [7:0] m_frame [FRAME_LEN];
  int         m_fill;
  logic       m_err;
  logic       m_valid;
  logic [7:0] m_cnt;
  int         m_ready = 0;

  typedef struct {
    logic [7:0] addr;
    logic       exp_err;
  } ev_vec_t;

  typedef struct {
    logic [AW-1:0] rd_addr;
    logic [7:0]    exp;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_fill  = 0;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_cnt   = 8'd0;
  endtask

  task automatic model_event(input logic [7:0] addr, input logic [7:0] data);
    int idx;
    if (addr == 8'd0 || int'(addr) > FRAME_LEN) begin
      m_err = 1'b1;
      return;
    end
    idx = FRAME_LEN - int'(addr);
    if (idx == 0) begin
      if (m_fill > 0) m_err = 1'b1;
      m_part[0] = data;
      m_fill    = 1;
    end else if (m_fill > 0 && idx == m_fill) begin
      m_part[idx] = data;
      m_fill++;
      if (m_fill == FRAME_LEN) begin
        for (int i = 0; i < FRAME_LEN; i++) m_frame[i] = m_part[i];
        m_valid = 1'b1;
        m_cnt   = m_cnt + 8'd1;
        m_ready++;
        m_fill  = 0;
      end
    end else begin
      m_err  = 1'b1;
      m_fill = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_wr_n = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One strobe: low for low_cycles, then two high cycles before the next.
  task automatic send_byte(input logic [7:0] addr, input logic [7:0] data, input int low_cycles);
    bus.rx_addr = addr;
    bus.rx_data = data;
    bus.rx_wr_n = 1'b0;
    repeat (low_cycles) tick();
    bus.rx_wr_n = 1'b1;
    bus.rx_addr = 8'($urandom);
    bus.rx_data = 8'($urandom);
    repeat (2) tick();
    model_event(addr, data);
  endtask

  function automatic logic [7:0] frame_byte(input int mode, input int idx);
    case (mode)
      0:       return 8'(idx) ^ 8'hA5;
      1:       return 8'(idx);
      default: return 8'($urandom);
    endcase
  endfunction

  // Sends idx first..last of a frame (addresses FRAME_LEN-first downwards).
  task automatic send_range(input int first, input int last, input int mode, input int low_cycles);
    for (int i = first; i <= last; i++)
      send_byte(8'(FRAME_LEN - i), frame_byte(mode, i), low_cycles);
  endtask

  task automatic check_state(input string tag);
    repeat (3) tick();
    check($sformatf("%s frame_cnt", tag), 32'(bus.frame_cnt), 32'(m_cnt));
    check($sformatf("%s frame_valid", tag), 32'(bus.frame_valid), 32'(m_valid));
    check($sformatf("%s frame_err", tag), 32'(bus.frame_err), 32'(m_err));
    check($sformatf("%s ready pulses", tag), 32'(ready_seen), 32'(m_ready));
  endtask

  task automatic check_reads(input string tag, input int count);
    int a;
    for (int i = 0; i < count; i++) begin
      a = (count >= FRAME_LEN + 16) ? i : int'($urandom_range(0, 127));
      bus.rd_addr = AW'(a);
      tick();
      check($sformatf("%s rd[%0d]", tag, a), 32'(bus.rd_data),
            32'((a < FRAME_LEN) ? m_frame[a] : 8'd0));
    end
  endtask

  ev_vec_t ev_tab [6];
  rd_vec_t rd_tab [6];

  initial begin
    int r0;
    ev_tab[0] = '{addr: 8'd0,   exp_err: 1'b1};
    ev_tab[1] = '{addr: 8'd113, exp_err: 1'b1};
    ev_tab[2] = '{addr: 8'd255, exp_err: 1'b1};
    ev_tab[3] = '{addr: 8'd111, exp_err: 1'b1};
    ev_tab[4] = '{addr: 8'd1,   exp_err: 1'b1};
    ev_tab[5] = '{addr: 8'd112, exp_err: 1'b0};
    rd_tab[0] = '{rd_addr: 7'd0,   exp: 8'hA5};
    rd_tab[1] = '{rd_addr: 7'd5,   exp: 8'hA0};
    rd_tab[2] = '{rd_addr: 7'd64,  exp: 8'hE5};
    rd_tab[3] = '{rd_addr: 7'd111, exp: 8'hCA};
    rd_tab[4] = '{rd_addr: 7'd112, exp: 8'h00};
    rd_tab[5] = '{rd_addr: 7'd127, exp: 8'h00};

    rst         = 1'b1;
    bus.rx_wr_n = 1'b1;
    bus.rx_addr = 8'd0;
    bus.rx_data = 8'd0;
    bus.rd_addr = '0;
    model_reset();
    repeat (2) tick();
    check("reset rd_data", 32'(bus.rd_data), 32'd0);
    check("reset frame_ready", 32'(bus.frame_ready), 32'd0);
    check("reset frame_valid", 32'(bus.frame_valid), 32'd0);
    check("reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("reset frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;

    // Lone events straight after reset: only the frame-start address is clean.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      send_byte(ev_tab[v].addr, 8'h3C, 1);
      tick();
      check($sformatf("event addr %0d err", ev_tab[v].addr), 32'(bus.frame_err), 32'(ev_tab[v].exp_err));
      check($sformatf("event addr %0d cnt", ev_tab[v].addr), 32'(bus.frame_cnt), 32'd0);
    end

    // Nominal frame.
    do_reset();
    r0 = ready_seen;
    send_range(0, FRAME_LEN - 1, 0, 1);
    check_state("nominal");
    check("nominal one pulse", 32'(ready_seen - r0), 32'd1);
    check("nominal cnt", 32'(bus.frame_cnt), 32'd1);
    check("nominal valid", 32'(bus.frame_valid), 32'd1);
    check("nominal err", 32'(bus.frame_err), 32'd0);
    for (int v = 0; v < 6; v++) begin
      bus.rd_addr = rd_tab[v].rd_addr;
      tick();
      check($sformatf("table rd[%0d]", rd_tab[v].rd_addr), 32'(bus.rd_data), 32'(rd_tab[v].exp));
    end
    check_reads("nominal", FRAME_LEN + 16);

    // Ping-pong: the old frame stays readable until the new one swaps in.
    send_range(0, FRAME_LEN - 2, 1, 1);
    bus.rd_addr = 7'd5;
    tick();
    check("pingpong before swap", 32'(bus.rd_data), 32'h A0);
    send_range(FRAME_LEN - 1, FRAME_LEN - 1, 1, 1);
    repeat (3) tick();
    check("pingpong after swap", 32'(bus.rd_data), 32'h05);
    check("pingpong cnt", 32'(bus.frame_cnt), 32'd2);
    check_state("pingpong");
    check_reads("pingpong", FRAME_LEN + 16);

    // Long strobe: ten low cycles per byte still count as one byte each.
    r0 = ready_seen;
    send_range(0, FRAME_LEN - 1, 2, 10);
    check_state("long strobe");
    check("long strobe one pulse", 32'(ready_seen - r0), 32'd1);
    check("long strobe cnt", 32'(bus.frame_cnt), 32'd3);
    check_reads("long strobe", 24);

    // Gap: 112, 111, 109 aborts; a clean frame then completes, error sticks.
    do_reset();
    r0 = ready_seen;
    send_byte(8'd112, 8'h11, 1);
    send_byte(8'd111, 8'h22, 1);
    send_byte(8'd109, 8'h33, 1);
    send_byte(8'd108, 8'h44, 1);
    repeat (3) tick();
    check("gap err", 32'(bus.frame_err), 32'd1);
    check("gap no pulse", 32'(ready_seen - r0), 32'd0);
    send_range(0, FRAME_LEN - 1, 2, 2);
    check_state("gap recover");
    check("gap recover cnt", 32'(bus.frame_cnt), 32'd1);
    check("gap recover err", 32'(bus.frame_err), 32'd1);
    check_reads("gap recover", 24);

    // Resync: a new frame start after 50 bytes restarts assembly.
    do_reset();
    r0 = ready_seen;
    send_range(0, 49, 0, 1);
    send_range(0, FRAME_LEN - 1, 2, 1);
    check_state("resync");
    check("resync one pulse", 32'(ready_seen - r0), 32'd1);
    check("resync err", 32'(bus.frame_err), 32'd1);
    check_reads("resync", FRAME_LEN + 16);

    // Reset mid-frame.
    send_range(0, 59, 1, 1);
    rst = 1'b1;
    tick();
    check("midreset rd_data", 32'(bus.rd_data), 32'd0);
    check("midreset frame_ready", 32'(bus.frame_ready), 32'd0);
    check("midreset frame_valid", 32'(bus.frame_valid), 32'd0);
    check("midreset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    check("midreset frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    model_reset();
    send_range(0, FRAME_LEN - 1, 0, 1);
    check_state("after midreset");
    check("after midreset cnt", 32'(bus.frame_cnt), 32'd1);
    check_reads("after midreset", FRAME_LEN + 16);

    // Randomized stream: mostly in-order bytes with occasional wild addresses.
    for (int round = 0; round < 8; round++) begin
      for (int n = 0; n < 160; n++) begin
        logic [7:0] a;
        if ($urandom_range(0, 99) < 90) a = 8'(FRAME_LEN - m_fill);
        else                            a = 8'($urandom_range(0, 120));
        send_byte(a, 8'($urandom), int'($urandom_range(1, 3)));
      end
      check_state($sformatf("random round %0d", round));
      if (m_valid) check_reads($sformatf("random round %0d", round), 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
